// File: rtl/ex_stage_muldiv.sv
// Purpose: MIPS execute stage. Resolves operand forwarding, selects the destination register, runs a
//          single-cycle ALU, and owns the registered EX/MEM outputs.
// Latency: ALU ops produce a result one cycle after acceptance. MULT/MULTU/DIV/DIVU keep the stage
//          busy for WIDTH cycles and then update HI/LO.
// Backpressure: in_ready = !busy, decoded from state only. While a multiply or divide runs, ID/EX holds.
// Optional feature: define EX_MULDIV_EN to build the iterative multiply/divide unit, HI/LO and its FSM.
//          Without it, ops 8-13 return 0, busy is tied to 0 and in_ready is tied to 1.
// Ports: clk/rst_n; in_valid/in_ready handshake; reg_read1/reg_read2/immediate operands;
//        wb_write_data/mem_alu_result forwarding sources; rt/rd/reg_dst destination select;
//        alu_op/forward_a/forward_b/alu_src control; out_valid/alu_result/write_data_out/rd_out EX/MEM
//        register; busy.
module ex_stage_muldiv #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   reg_read1,
    input  logic [WIDTH-1:0]   reg_read2,
    input  logic [WIDTH-1:0]   immediate,
    input  logic [WIDTH-1:0]   wb_write_data,
    input  logic [WIDTH-1:0]   mem_alu_result,
    input  logic [RADDR_W-1:0] rt,
    input  logic [RADDR_W-1:0] rd,
    input  logic [3:0]         alu_op,
    input  logic [1:0]         forward_a,
    input  logic [1:0]         forward_b,
    input  logic [1:0]         reg_dst,
    input  logic               alu_src,
    output logic               out_valid,
    output logic [WIDTH-1:0]   alu_result,
    output logic [WIDTH-1:0]   write_data_out,
    output logic [RADDR_W-1:0] rd_out,
    output logic               busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLLV = 4'd7;
`ifdef EX_MULDIV_EN
    localparam logic [3:0] OP_MFHI = 4'd12;
    localparam logic [3:0] OP_MFLO = 4'd13;
`endif

    logic               accept;
    logic               is_muldiv;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   rt_fwd;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   alu_res;
    logic [RADDR_W-1:0] dest;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_result_q, alu_result_d;
    logic [WIDTH-1:0]   write_data_out_q, write_data_out_d;
    logic [RADDR_W-1:0] rd_out_q, rd_out_d;

    assign accept = in_valid & in_ready;

    // Forwarding is applied to rt before the immediate select, so store data always carries the forwarded rt.
    always_comb begin
        op_a   = reg_read1;
        rt_fwd = reg_read2;
        case (forward_a)
            2'b01:   op_a = wb_write_data;
            2'b10:   op_a = mem_alu_result;
            default: op_a = reg_read1;
        endcase
        case (forward_b)
            2'b01:   rt_fwd = wb_write_data;
            2'b10:   rt_fwd = mem_alu_result;
            default: rt_fwd = reg_read2;
        endcase
        op_b = alu_src ? immediate : rt_fwd;
    end

    always_comb begin
        case (reg_dst)
            2'b01:   dest = rd;
            2'b10:   dest = RADDR_W'(31);
            default: dest = rt;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic {S_IDLE, S_RUN} state_t;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    // Multiply: acc = running product, opa = multiplicand shifted left, opb = multiplier shifted right.
    // Divide:   acc = {remainder, dividend/quotient}, opa[WIDTH-1:0] = divisor magnitude.
    logic [2*WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, acc_step, prod;
    logic [WIDTH-1:0]   opb_q, opb_d, dvd_q, dvd_d, mag_a, mag_b, quo, rem;
    logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic               sgn;
    logic [WIDTH:0]     trial, diff;

    assign is_muldiv = (alu_op[3:2] == 2'b10);
    assign sgn       = !alu_op[0];
    assign busy      = (state_q == S_RUN);
    assign in_ready  = !busy;
    assign mag_a     = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b     = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;

    // One shift-add or one restoring-divide step per cycle.
    always_comb begin
        trial = acc_q[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, opa_q[WIDTH-1:0]};
        if (is_div_q) begin
            if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step = acc_q + (opb_q[0] ? opa_q : '0);
        end
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem  = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        dvd_d     = dvd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        if (state_q == S_IDLE) begin
            if (accept && is_muldiv) begin
                state_d   = S_RUN;
                cnt_d     = CW'(WIDTH);
                is_div_d  = alu_op[1];
                neg_d     = sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                neg_rem_d = sgn && op_a[WIDTH-1];
                dz_d      = (op_b == '0);
                dvd_d     = op_a;
                opb_d     = mag_b;
                if (alu_op[1]) begin
                    acc_d = {{WIDTH{1'b0}}, mag_a};
                    opa_d = {{WIDTH{1'b0}}, mag_b};
                end else begin
                    acc_d = '0;
                    opa_d = {{WIDTH{1'b0}}, mag_a};
                end
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            acc_d = acc_step;
            opa_d = is_div_q ? opa_q : (opa_q << 1);
            opb_d = opb_q >> 1;
            if (cnt_q == CW'(1)) begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = dvd_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            dvd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            dvd_q     <= dvd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end
`else
    assign is_muldiv = 1'b0;
    assign busy      = 1'b0;
    assign in_ready  = 1'b1;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLLV: alu_res = op_b << op_a[SHW-1:0];
`ifdef EX_MULDIV_EN
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
`endif
            default: alu_res = '0;
        endcase
    end

    // A mul/div writes a harmless bubble (result 0 to $0) so no register write happens downstream.
    always_comb begin
        out_valid_d      = accept;
        alu_result_d     = alu_result_q;
        write_data_out_d = write_data_out_q;
        rd_out_d         = rd_out_q;
        if (accept) begin
            alu_result_d     = is_muldiv ? '0 : alu_res;
            write_data_out_d = rt_fwd;
            rd_out_d         = is_muldiv ? '0 : dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            alu_result_q     <= '0;
            write_data_out_q <= '0;
            rd_out_q         <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            alu_result_q     <= alu_result_d;
            write_data_out_q <= write_data_out_d;
            rd_out_q         <= rd_out_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_result     = alu_result_q;
    assign write_data_out = write_data_out_q;
    assign rd_out         = rd_out_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
module tb_ex_stage_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  reg_read1 = '0, reg_read2 = '0, immediate = '0;
    logic [W-1:0]  wb_write_data = '0, mem_alu_result = '0;
    logic [4:0]    rt = '0, rd = '0;
    logic [3:0]    alu_op = '0;
    logic [1:0]    forward_a = '0, forward_b = '0, reg_dst = '0;
    logic          alu_src = 1'b0;
    logic          out_valid;
    logic [W-1:0]  alu_result, write_data_out;
    logic [4:0]    rd_out;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] model_hi = '0, model_lo = '0;

    ex_stage_muldiv #(.WIDTH(W), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .reg_read1(reg_read1), .reg_read2(reg_read2), .immediate(immediate),
        .wb_write_data(wb_write_data), .mem_alu_result(mem_alu_result),
        .rt(rt), .rd(rd), .alu_op(alu_op), .forward_a(forward_a), .forward_b(forward_b),
        .reg_dst(reg_dst), .alu_src(alu_src), .out_valid(out_valid), .alu_result(alu_result),
        .write_data_out(write_data_out), .rd_out(rd_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] rr1, rr2, imm, wb, mem;
        logic [1:0]   fa, fb, rdst;
        logic         asrc;
        logic [4:0]   rt, rd;
        logic [W-1:0] exp_res, exp_wd;
        logic [4:0]   exp_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        alu_op = v.op; reg_read1 = v.rr1; reg_read2 = v.rr2; immediate = v.imm;
        wb_write_data = v.wb; mem_alu_result = v.mem; forward_a = v.fa; forward_b = v.fb;
        reg_dst = v.rdst; alu_src = v.asrc; rt = v.rt; rd = v.rd;
    endtask

    // Presents one instruction for exactly one edge and samples 1 time unit after it.
    task automatic issue(input vec_t v);
        set_inputs(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic vec_t mkvec(input logic [3:0] op, input logic [W-1:0] rr1, input logic [W-1:0] rr2,
                                   input logic [W-1:0] imm, input logic [W-1:0] wb, input logic [W-1:0] mem,
                                   input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] rdst,
                                   input logic asrc, input logic [4:0] rtv, input logic [4:0] rdv,
                                   input logic [W-1:0] er, input logic [W-1:0] ew, input logic [4:0] ed);
        vec_t v;
        v.op = op; v.rr1 = rr1; v.rr2 = rr2; v.imm = imm; v.wb = wb; v.mem = mem;
        v.fa = fa; v.fb = fb; v.rdst = rdst; v.asrc = asrc; v.rt = rtv; v.rd = rdv;
        v.exp_res = er; v.exp_wd = ew; v.exp_rd = ed;
        return v;
    endfunction

    // Reference: pick sources, apply the instruction's arithmetic meaning.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [W-1:0] a, t, b;
        int sh;
        a = (v.fa == 2'd1) ? v.wb : (v.fa == 2'd2) ? v.mem : v.rr1;
        t = (v.fb == 2'd1) ? v.wb : (v.fb == 2'd2) ? v.mem : v.rr2;
        b = v.asrc ? v.imm : t;
        sh = int'(a % 32);
        case (v.op)
            4'd0: r.exp_res = a + b;
            4'd1: r.exp_res = a - b;
            4'd2: r.exp_res = a & b;
            4'd3: r.exp_res = a | b;
            4'd4: r.exp_res = a ^ b;
            4'd5: r.exp_res = ~(a | b);
            4'd6: r.exp_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: r.exp_res = b * (32'd1 << sh);
`ifdef EX_MULDIV_EN
            4'd12: r.exp_res = model_hi;
            4'd13: r.exp_res = model_lo;
`endif
            default: r.exp_res = '0;
        endcase
        r.exp_wd = t;
        r.exp_rd = (v.rdst == 2'd1) ? v.rd : (v.rdst == 2'd2) ? 5'd31 : v.rt;
        return r;
    endfunction

    function automatic vec_t rand_vec(input logic [3:0] op);
        vec_t v;
        v = mkvec(op, $urandom, $urandom, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), '0, '0, '0);
        if ($urandom_range(0, 3) == 0) v.rr1 = {W{1'b1}};
        return model(v);
    endfunction

`ifdef EX_MULDIV_EN
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    task automatic md_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        logic [63:0] up;
        case (op)
            4'd8: begin
                p = longint'($signed(a)) * longint'($signed(b));
                model_hi = p[63:32]; model_lo = p[31:0];
            end
            4'd9: begin
                up = {32'd0, a} * {32'd0, b};
                model_hi = up[63:32]; model_lo = up[31:0];
            end
            default: begin
                if (b == 0) begin
                    model_lo = '1; model_hi = a;
                end else if (op == 4'd10 && a == MINV && b == '1) begin
                    model_lo = MINV; model_hi = '0;
                end else if (op == 4'd10) begin
                    model_lo = $signed(a) / $signed(b); model_hi = $signed(a) % $signed(b);
                end else begin
                    model_lo = a / b; model_hi = a % b;
                end
            end
        endcase
    endtask

    // Issues a mul/div, holds MFLO pending through the stall, then reads MFLO and MFHI.
    task automatic run_md(input string nm, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int stall;
        vec_t v;
        md_model(op, a, b);
        v = mkvec(op, a, b, '0, '0, '0, 2'd0, 2'd0, 2'd1, 1'b0, 5'd4, 5'd5, '0, '0, '0);
        check({nm, " ready_before"}, 64'(in_ready), 64'd1);
        set_inputs(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check({nm, " bubble_valid"}, 64'(out_valid), 64'd1);
        check({nm, " bubble_res"}, 64'(alu_result), 64'd0);
        check({nm, " bubble_rd"}, 64'(rd_out), 64'd0);
        check({nm, " busy"}, 64'(busy), 64'd1);
        alu_op = 4'd13; rd = 5'd2;
        stall = 0;
        while (in_ready == 1'b0 && stall < 100) begin
            stall++;
            @(posedge clk); #1;
        end
        check({nm, " stall_cycles"}, 64'(stall), 64'd32);
        @(posedge clk); #1;
        check({nm, " mflo"}, 64'(alu_result), 64'(model_lo));
        check({nm, " mflo_rd"}, 64'(rd_out), 64'd2);
        alu_op = 4'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, " mfhi"}, 64'(alu_result), 64'(model_hi));
    endtask
`endif

    initial begin
        vec_t r;
        logic [W-1:0] held;

        vecs[0]  = mkvec(4'd0, 1, 5, 3, 0, 9, 2'd0, 2'd2, 2'd1, 1'b1, 5'd3, 5'd7, 32'd4, 32'd9, 5'd7);
        vecs[1]  = mkvec(4'd6, 32'hFFFF_FFFF, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd3, 5'd8, 32'd1, 32'd1, 5'd3);
        vecs[2]  = mkvec(4'd1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd2, 1'b0, 5'd3, 5'd8, 32'hFFFF_FFFF, 32'd1, 5'd31);
        vecs[3]  = mkvec(4'd3, 99, 5, 0, 10, 0, 2'd1, 2'd0, 2'd3, 1'b0, 5'd4, 5'd8, 32'd15, 32'd5, 5'd4);
        vecs[4]  = mkvec(4'd2, 32'hF0, 32'h3C, 0, 1, 2, 2'd3, 2'd3, 2'd1, 1'b0, 5'd4, 5'd9, 32'h30, 32'h3C, 5'd9);
        vecs[5]  = mkvec(4'd4, 0, 32'h0FF0, 0, 0, 32'hFF00, 2'd2, 2'd0, 2'd0, 1'b0, 5'd6, 5'd9, 32'hF0F0, 32'h0FF0, 5'd6);
        vecs[6]  = mkvec(4'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd1, 5'd9, 32'hFFFF_FFFF, 32'd0, 5'd1);
        vecs[7]  = mkvec(4'd7, 4, 1, 3, 32'h77, 0, 2'd0, 2'd1, 2'd1, 1'b1, 5'd1, 5'd10, 32'h30, 32'h77, 5'd10);
        vecs[8]  = mkvec(4'd7, 35, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd11, 5'd10, 32'd8, 32'd1, 5'd11);
        vecs[9]  = mkvec(4'd14, 6, 7, 0, 0, 0, 2'd0, 2'd0, 2'd1, 1'b0, 5'd11, 5'd12, 32'd0, 32'd7, 5'd12);
        vecs[10] = mkvec(4'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd13, 5'd12, 32'd1, 32'hFFFF_FFFF, 5'd13);
        vecs[11] = mkvec(4'd0, 32'hFFFF_FFFF, 2, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd14, 5'd12, 32'd1, 32'd2, 5'd14);

        // Reset state
        #12;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst alu_result", 64'(alu_result), 64'd0);
        check("rst write_data", 64'(write_data_out), 64'd0);
        check("rst rd_out", 64'(rd_out), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, back-to-back issue
        for (int i = 0; i < 12; i++) begin
            set_inputs(vecs[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d res", i), 64'(alu_result), 64'(vecs[i].exp_res));
            check($sformatf("vec%0d wdata", i), 64'(write_data_out), 64'(vecs[i].exp_wd));
            check($sformatf("vec%0d rd", i), 64'(rd_out), 64'(vecs[i].exp_rd));
        end
        in_valid = 1'b0;
        held = vecs[11].exp_res;
        @(posedge clk); #1;
        check("idle out_valid", 64'(out_valid), 64'd0);
        check("idle hold res", 64'(alu_result), 64'(held));
        check("idle hold rd", 64'(rd_out), 64'(vecs[11].exp_rd));

`ifdef EX_MULDIV_EN
        run_md("mult_-3x7", 4'd8, 32'hFFFF_FFFD, 32'd7);
        check("mult lo model", 64'(model_lo), 64'hFFFF_FFEB);
        run_md("div_-7/2", 4'd10, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_5/0", 4'd11, 32'd5, 32'd0);
        run_md("div_min/-1", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_-9/0", 4'd10, 32'hFFFF_FFF7, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] a, b;
            a = $urandom; b = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(0, 30);
            run_md($sformatf("rand_md%0d", i), 4'(8 + (i % 4)), a, b);
        end
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 11);
            r = rand_vec(4'(k < 8 ? k : k + 4));
            issue(r);
            check($sformatf("rand%0d res", i), 64'(alu_result), 64'(r.exp_res));
            check($sformatf("rand%0d wdata", i), 64'(write_data_out), 64'(r.exp_wd));
            check($sformatf("rand%0d rd", i), 64'(rd_out), 64'(r.exp_rd));
        end

        // Reset in the middle of a DIVU aborts it and clears HI/LO
        r = mkvec(4'd11, 32'd100, 32'd7, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, '0, '0, '0);
        issue(r);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_hi = '0; model_lo = '0;
        @(posedge clk); #1;
        r = model(mkvec(4'd12, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 1'b0, 5'd1, 5'd3, '0, '0, '0));
        issue(r);
        check("post_abort mfhi", 64'(alu_result), 64'd0);
        r.op = 4'd13;
        issue(r);
        check("post_abort mflo", 64'(alu_result), 64'd0);
`else
        // No multiply/divide unit: ops 8-13 are plain zero-result instructions with no stall
        for (int op = 8; op < 14; op++) begin
            r = mkvec(4'(op), 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 2'd0, 2'd0, 2'd1, 1'b0, 5'd3, 5'(op), 32'd0, 32'd7, 5'(op));
            check($sformatf("nomd op%0d ready_before", op), 64'(in_ready), 64'd1);
            issue(r);
            check($sformatf("nomd op%0d ready_after", op), 64'(in_ready), 64'd1);
            check($sformatf("nomd op%0d busy", op), 64'(busy), 64'd0);
            check($sformatf("nomd op%0d res", op), 64'(alu_result), 64'd0);
            check($sformatf("nomd op%0d rd", op), 64'(rd_out), 64'(op));
        end
        for (int i = 0; i < 40; i++) begin
            r = rand_vec(4'($urandom_range(0, 15)));
            issue(r);
            check($sformatf("rand%0d ready", i), 64'(in_ready), 64'd1);
            check($sformatf("rand%0d res", i), 64'(alu_result), 64'(r.exp_res));
            check($sformatf("rand%0d wdata", i), 64'(write_data_out), 64'(r.exp_wd));
            check($sformatf("rand%0d rd", i), 64'(rd_out), 64'(r.exp_rd));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
